// File: rtl/mux_arbiter_pkg.sv
// Shared types and defaults for the two-requester mux arbiter.
package mux_arbiter_pkg;

  localparam int unsigned DefaultN    = 4;
  localparam int unsigned DefaultHold = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGntX = 2'b01,
    StGntY = 2'b10
  } state_e;

endpackage

// File: rtl/mux2_n.sv
// N-bit 2:1 data select; sel=0 picks a, sel=1 picks b.
module mux2_n #(
  parameter int unsigned N = 4
) (
  input  logic         sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out
);

  always_comb begin
    out = sel ? b : a;
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter with bounded hold, steering X or Y data onto a registered output.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned N    = DefaultN,
  parameter int unsigned HOLD = DefaultHold
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         req_x,
  input  logic [N-1:0] x,
  input  logic         req_y,
  input  logic [N-1:0] y,
  output logic         gnt_x,
  output logic         gnt_y,
  output logic         s,
  output logic [N-1:0] m,
  output logic         valid,
  output logic [9:4]   LEDR
);

  localparam int unsigned     CntW   = $clog2(HOLD);
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD - 1);

  state_e          state_q, state_d;
  state_e          last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    m_q, m_d;
  logic [N-1:0]    sel_data;

  mux2_n #(
    .N(N)
  ) u_mux2_n (
    .sel(state_d == StGntY),
    .a  (x),
    .b  (y),
    .out(sel_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_x && req_y) begin
          state_d = (last_q == StGntY) ? StGntX : StGntY;
        end else if (req_x) begin
          state_d = StGntX;
        end else if (req_y) begin
          state_d = StGntY;
        end
      end
      // Hold expiry only matters when the other side is waiting.
      StGntX: begin
        if (req_x && !(req_y && cnt_q == CntMax)) begin
          state_d = StGntX;
        end else if (req_y) begin
          state_d = StGntY;
        end else begin
          state_d = StIdle;
        end
      end
      StGntY: begin
        if (req_y && !(req_x && cnt_q == CntMax)) begin
          state_d = StGntY;
        end else if (req_x) begin
          state_d = StGntX;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    m_d    = m_q;
    if (state_d != state_q || state_d == StIdle) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (state_d != state_q && state_d != StIdle) begin
      last_d = state_d;
    end
    if (state_d != StIdle) begin
      m_d = sel_data;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StIdle;
      last_q  <= StGntY;
      cnt_q   <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    gnt_x = (state_q == StGntX);
    gnt_y = (state_q == StGntY);
    s     = gnt_y;
    valid = gnt_x | gnt_y;
    m     = m_q;
    LEDR  = {gnt_x, gnt_y, state_q, 2'b00};
  end

endmodule
